// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN operand path.
//   DW        element width in bits
//   N_IN      input-matrix elements (4x4, row-major)
//   N_F       filter elements (3x3, row-major)
//   FRAME_LEN bytes per load frame (matrix then filter)
//   IDX_W     width of the frame byte index
//   ldr_state_t  operand_loader control states
package cnn_pkg;
  localparam int DW        = 8;
  localparam int N_IN      = 16;
  localparam int N_F       = 9;
  localparam int FRAME_LEN = N_IN + N_F;
  localparam int IDX_W     = 5;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} ldr_state_t;
endpackage

// File: rtl/operand_loader_if.sv
// Valid/ready byte stream feeding operand_loader.
//   in_valid  byte present on in_data
//   in_data   operand byte
//   in_last   final byte of the frame (meaningful only with in_valid)
//   in_ready  loader accepts a byte this cycle
interface operand_loader_if #(parameter int DW = 8);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/byte_regfile.sv
// Write-indexed register array with a flat read-out of every entry.
//   clk, rst   clock, synchronous active-high clear of all entries
//   wr_en_i    write strobe
//   wr_idx_i   entry to write
//   wr_data_i  write data
//   rd_flat_o  all entries, entry i in rd_flat_o[i]
module byte_regfile #(
  parameter int DW    = 8,
  parameter int DEPTH = 25,
  parameter int IDX_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [IDX_W-1:0]           wr_idx_i,
  input  logic [DW-1:0]              wr_data_i,
  output logic [DEPTH-1:0][DW-1:0]   rd_flat_o
);
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [DW-1:0] ent_q;
    always_ff @(posedge clk) begin
      if (rst)                                      ent_q <= '0;
      else if (wr_en_i && (wr_idx_i == IDX_W'(i)))  ent_q <= wr_data_i;
    end
    assign rd_flat_o[i] = ent_q;
  end
endmodule

// File: rtl/operand_loader.sv
// Streams a 25-byte frame (16 matrix bytes then 9 filter bytes) into
// operand storage and presents it as flat buses to the memory stage.
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle pulse starting a frame (ignored while loading)
//   s_if       byte stream (slave side)
//   mat_flat   matrix, element i at [DW*i +: DW]
//   filt_flat  filter, element j at [DW*j +: DW]
//   load_done  last frame loaded cleanly
//   frame_err  last frame malformed (early or missing in_last)
//   checksum   mod-2^DW sum of bytes accepted in the current/last frame
module operand_loader
  import cnn_pkg::*;
#(
  parameter int DW   = cnn_pkg::DW,
  parameter int N_IN = cnn_pkg::N_IN,
  parameter int N_F  = cnn_pkg::N_F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  operand_loader_if.slave      s_if,
  output logic [N_IN*DW-1:0]   mat_flat,
  output logic [N_F*DW-1:0]    filt_flat,
  output logic                 load_done,
  output logic                 frame_err,
  output logic [DW-1:0]        checksum
);
  localparam int FLEN = N_IN + N_F;

  ldr_state_t              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DW-1:0]           csum_q, csum_d;
  logic                    wr_en;
  logic [FLEN-1:0][DW-1:0] rf_flat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    wr_en   = 1'b0;
    case (state_q)
      LOAD: begin
        // in_ready is 1 throughout LOAD, so in_valid alone means accept
        if (s_if.in_valid) begin
          wr_en  = 1'b1;
          csum_d = csum_q + s_if.in_data;
          if (idx_q == IDX_W'(FLEN - 1)) begin
            // index saturates here; the frame ends either way
            state_d = s_if.in_last ? DONE : ERR;
          end else begin
            idx_d = idx_q + 1'b1;
            if (s_if.in_last) state_d = ERR;
          end
        end
      end
      default: begin
        // IDLE/DONE/ERR: storage held, start opens a new frame
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
    endcase
  end

  // Outputs decode the state register directly, so they are registered
  assign s_if.in_ready = (state_q == LOAD);
  assign load_done     = (state_q == DONE);
  assign frame_err     = (state_q == ERR);
  assign checksum      = csum_q;

  byte_regfile #(.DW(DW), .DEPTH(FLEN), .IDX_W(IDX_W)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx_q),
    .wr_data_i (s_if.in_data),
    .rd_flat_o (rf_flat)
  );

  assign mat_flat  = rf_flat[N_IN-1:0];
  assign filt_flat = rf_flat[FLEN-1:N_IN];
endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  operand_loader_if #(.DW(DW)) s_if ();
  logic [N_IN*DW-1:0] mat_flat;
  logic [N_F*DW-1:0]  filt_flat;
  logic               load_done, frame_err;
  logic [DW-1:0]      checksum;

  operand_loader dut (
    .clk(clk), .rst(rst), .start(start), .s_if(s_if),
    .mat_flat(mat_flat), .filt_flat(filt_flat),
    .load_done(load_done), .frame_err(frame_err), .checksum(checksum)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    bit          gap;        // in_valid low on every other cycle, starting low
    int          last_pos;   // index carrying in_last (-1: never)
    int          start_at;   // index at which start is re-pulsed (-1: never)
    int          n_bytes;    // bytes to stream
    bit          exp_done;
    bit          exp_err;
    int          exp_edges;  // edges after the start edge until done/err
    logic [7:0]  exp_csum;
  } vec_t;

  typedef struct { int idx; logic [7:0] val; } sb_t;

  logic [7:0] frame [FRAME_LEN];
  vec_t       vt [5];
  sb_t        sb [$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] elem(int i);
    if (i < N_IN) return mat_flat[i*DW +: DW];
    return filt_flat[(i-N_IN)*DW +: DW];
  endfunction

  task automatic idle_bus();
    s_if.in_valid = 1'b0;
    s_if.in_data  = 8'h00;
    s_if.in_last  = 1'b0;
    start         = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Pulses start, then streams bytes; pushes each accepted byte to sb.
  task automatic stream(input vec_t v, output int edges);
    int k;
    bit ph;
    bit acc;
    k = 0; ph = 1'b0; edges = 0;
    pulse_start();
    while (k < v.n_bytes && edges < 200) begin
      s_if.in_valid = !(v.gap && !ph);
      ph            = !ph;
      s_if.in_data  = s_if.in_valid ? frame[k] : 8'hA5;
      // in_last held high on idle cycles must be ignored
      s_if.in_last  = s_if.in_valid ? (k == v.last_pos) : 1'b1;
      start         = s_if.in_valid && (k == v.start_at);
      acc           = s_if.in_valid && s_if.in_ready;
      @(posedge clk);
      edges++;
      if (acc) begin
        sb.push_back('{k, frame[k]});
        k++;
      end
      #1;
    end
    idle_bus();
    if (edges >= 200) chk("stream_timeout", 128'(edges), 128'(v.exp_edges));
  endtask

  task automatic drain_sb(string tag);
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("%s_elem%0d", tag, e.idx), 128'(elem(e.idx)), 128'(e.val));
    end
  endtask

  initial begin
    int edges;
    logic [7:0] init_bytes [FRAME_LEN] = '{1,4,7,5,0,8,6,3,5,10,4,2,3,6,9,7,
                                            3,0,2,1,1,0,2,2,1};
    frame = init_bytes;
    //        gap last start n   done err edges csum
    vt[0] = '{1'b0, 24, -1, 25, 1'b1, 1'b0, 25, 8'h5C};
    vt[1] = '{1'b1, 24, -1, 25, 1'b1, 1'b0, 50, 8'h5C};
    vt[2] = '{1'b0, 10, -1, 11, 1'b0, 1'b1, 11, 8'h35};
    vt[3] = '{1'b0, -1, -1, 25, 1'b0, 1'b1, 25, 8'h5C};
    vt[4] = '{1'b0, 24,  4, 25, 1'b1, 1'b0, 25, 8'h5C};

    rst = 1'b1;
    idle_bus();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mat",   128'(mat_flat),      128'(0));
    chk("rst_filt",  128'(filt_flat),     128'(0));
    chk("rst_ready", 128'(s_if.in_ready), 128'(0));
    chk("rst_done",  128'(load_done),     128'(0));
    chk("rst_err",   128'(frame_err),     128'(0));
    chk("rst_csum",  128'(checksum),      128'(0));

    for (int i = 0; i < 5; i++) begin
      do_reset();
      stream(vt[i], edges);
      chk($sformatf("v%0d_edges", i), 128'(edges),         128'(vt[i].exp_edges));
      chk($sformatf("v%0d_done", i),  128'(load_done),     128'(vt[i].exp_done));
      chk($sformatf("v%0d_err", i),   128'(frame_err),     128'(vt[i].exp_err));
      chk($sformatf("v%0d_ready", i), 128'(s_if.in_ready), 128'(0));
      chk($sformatf("v%0d_csum", i),  128'(checksum),      128'(vt[i].exp_csum));
      drain_sb($sformatf("v%0d", i));
    end

    // Clean frame, then DONE holds storage and a restart keeps old elements
    do_reset();
    stream(vt[0], edges);
    sb.delete();
    chk("done_m0",   128'(mat_flat[7:0]),     128'(1));
    chk("done_m15",  128'(mat_flat[127:120]), 128'(7));
    chk("done_f0",   128'(filt_flat[7:0]),    128'(3));
    chk("done_f8",   128'(filt_flat[71:64]),  128'(1));
    s_if.in_valid = 1'b1; s_if.in_data = 8'hFF; s_if.in_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    idle_bus();
    chk("hold_ready", 128'(s_if.in_ready), 128'(0));
    chk("hold_done",  128'(load_done),     128'(1));
    chk("hold_m0",    128'(elem(0)),       128'(1));
    chk("hold_f8",    128'(elem(24)),      128'(1));
    pulse_start();
    chk("restart_done",  128'(load_done),     128'(0));
    chk("restart_ready", 128'(s_if.in_ready), 128'(1));
    chk("restart_csum",  128'(checksum),      128'(0));
    chk("restart_m15",   128'(elem(15)),      128'(7));

    // Error by missing in_last, then start recovers
    do_reset();
    stream(vt[3], edges);
    sb.delete();
    chk("err_flag", 128'(frame_err), 128'(1));
    pulse_start();
    chk("recov_err",   128'(frame_err),     128'(0));
    chk("recov_ready", 128'(s_if.in_ready), 128'(1));
    chk("recov_csum",  128'(checksum),      128'(0));

    // Early in_last: element 10 written, no done
    do_reset();
    stream(vt[2], edges);
    sb.delete();
    chk("early_m10",  128'(elem(10)),  128'(4));
    chk("early_done", 128'(load_done), 128'(0));

    // Reset after 12 accepted bytes clears everything
    do_reset();
    begin
      vec_t v12;
      v12 = vt[0];
      v12.n_bytes = 12;
      stream(v12, edges);
      sb.delete();
    end
    chk("mid_csum_pre", 128'(checksum), 128'(8'h37));
    chk("mid_m11_pre",  128'(elem(11)), 128'(2));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_mat",   128'(mat_flat),      128'(0));
    chk("mid_filt",  128'(filt_flat),     128'(0));
    chk("mid_csum",  128'(checksum),      128'(0));
    chk("mid_ready", 128'(s_if.in_ready), 128'(0));
    chk("mid_done",  128'(load_done),     128'(0));
    chk("mid_err",   128'(frame_err),     128'(0));
    // Still IDLE: a valid byte without start is not taken
    s_if.in_valid = 1'b1; s_if.in_data = 8'h11;
    @(posedge clk); #1;
    idle_bus();
    chk("mid_idle_m0", 128'(elem(0)),  128'(0));
    chk("mid_idle_cs", 128'(checksum), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/operand_loader.md
# operand_loader

Streaming loader that fills the 16-byte 4x4 input matrix and the 9-byte 3x3 filter through a valid/ready byte stream, then presents both as flat buses to the `memory` stage. It sits directly upstream of `memory` and replaces the fixed power-up operand values, so operands are runtime-loadable. `load_done` gates the controller's transition out of its load phase.

## Interface
Parameters:
- `DW`, 8, element width in bits
- `N_IN`, 16, input-matrix elements (row-major 4x4)
- `N_F`, 9, filter elements (row-major 3x3)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a load frame
- `in_valid`  in  1  byte present on `in_data`
- `in_data`  in  DW  operand byte
- `in_last`  in  1  marks final byte of frame
- `in_ready`  out  1  loader accepts a byte this cycle
- `mat_flat`  out  N_IN*DW  matrix; element i at bits [DW*i+DW-1 : DW*i]
- `filt_flat`  out  N_F*DW  filter; element j at bits [DW*j+DW-1 : DW*j]
- `load_done`  out  1  level; frame loaded without error
- `frame_err`  out  1  level; last frame malformed
- `checksum`  out  DW  mod-2^DW sum of bytes accepted in current/last frame

## Operation
- Clock `clk`; reset `rst` is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: state IDLE, `mat_flat`=0, `filt_flat`=0, `in_ready`=0, `load_done`=0, `frame_err`=0, `checksum`=0, index=0.
- States: IDLE, LOAD, DONE, ERR.
- IDLE: `in_ready`=0. `start` -> LOAD; index cleared to 0, `checksum` cleared.
- LOAD: `in_ready`=1. A byte is accepted on a cycle with `in_valid && in_ready`. Accepted byte at index k:
  - k<N_IN writes matrix element k.
  - Otherwise it writes filter element k-N_IN.
  - `checksum` += byte; index increments.
- Frame length is N_IN+N_F=25 bytes (index 0..24).
  - Accept at index 24 with `in_last`=1 -> DONE.
  - Accept at index 24 with `in_last`=0 -> ERR.
  - Accept at index <24 with `in_last`=1 -> ERR. The byte is still written.
- `in_last` without `in_valid` is ignored. `in_data` is don't-care when `in_valid`=0.
- DONE: `load_done`=1, `in_ready`=0, storage held. `start` -> LOAD, `load_done` cleared, index and `checksum` cleared. Stored elements keep old values until overwritten.
- ERR: `frame_err`=1, `in_ready`=0. `start` -> LOAD and clears `frame_err`.
- `start` in LOAD is ignored; the frame continues.
- Reset asserted mid-frame: everything returns to reset values next edge, with no partial data retained.
- Arithmetic: index 5 bits, saturates at 24. `checksum` wraps mod 256.

## Timing
- `in_ready` is a registered function of state: it rises the cycle after the `start` edge and falls the cycle after the accepting edge of byte 24 or an error byte.
- Storage is updated on the same edge the byte is accepted; the value is visible on `mat_flat`/`filt_flat` the following cycle.
- `load_done`/`frame_err` assert on the cycle after the final or erroneous accept.
- Minimum frame: `start` at cycle 0, bytes accepted cycles 1..25, `load_done`=1 at cycle 26.
- Gaps in `in_valid` stall the loader indefinitely with no timeout. The upstream side may hold `in_valid` high across cycles.

## Structure
- Shared package `cnn_pkg`:
  - `DW`, `N_IN`, `N_F`, `FRAME_LEN`=25
  - state enum `ldr_state_t` {IDLE, LOAD, DONE, ERR}
  - index width constant
- Sub-module `byte_regfile`: 25 x DW write-indexed register array with flat read-out, split into matrix/filter buses in the top. Control FSM and checksum stay in `operand_loader`.

## Test plan
- Reset, `start`, stream 1,4,7,5,0,8,6,3,5,10,4,2,3,6,9,7 then 3,0,2,1,1,0,2,2,1 back-to-back with `in_last` on byte 25 -> `load_done`=1 at cycle 26; `mat_flat[7:0]`=1, `mat_flat[127:120]`=7, `filt_flat[7:0]`=3, `filt_flat[71:64]`=1; `checksum`=0x5C; `frame_err`=0.
- Same frame with `in_valid` low every other cycle -> identical final outputs, `load_done` at cycle 51.
- `in_last` asserted with byte 11 (value 4) -> `frame_err`=1 next cycle, `in_ready`=0, matrix element 10 = 4, `load_done`=0.
- 25 bytes with `in_last` never asserted -> `frame_err`=1 after byte 25. Then `start` -> `frame_err`=0, `in_ready`=1.
- `rst` asserted after 12 accepted bytes -> next cycle all buses 0, `checksum`=0, state IDLE, `in_ready`=0.
- `start` pulsed during LOAD at byte 5 -> ignored; the frame completes normally with `checksum`=0x5C.
